// File: rtl/conv_rescale.sv
// Requantizes a vector of signed accumulators to packed int8, LANES_PER_CYC lanes per cycle,
// publishing the whole vector at once with a one-cycle valid pulse.
module conv_rescale #(
   parameter int LANES         = 40,
   parameter int ACC_W         = 24,
   parameter int MUL_W         = 16,
   parameter int LANES_PER_CYC = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_i,
   input  logic [ACC_W*LANES-1:0] data_i,
   input  logic [MUL_W-1:0]       scale_i,
   input  logic [4:0]             shift_i,
   input  logic                   relu_en,
   output logic                   busy_o,
   output logic [8*LANES-1:0]     ofmap_rescaled,
   output logic                   valid_o_rescaled
);

   localparam int G     = LANES / LANES_PER_CYC;
   localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
   localparam int P_W   = ACC_W + MUL_W + 1;
   localparam logic [GRP_W-1:0]      LAST_GRP  = GRP_W'(G - 1);
   localparam logic [P_W-1:0]        ROUND_ONE = {{(P_W-1){1'b0}}, 1'b1};
   localparam logic signed [P_W-1:0] SAT_MAX   = P_W'(127);
   localparam logic signed [P_W-1:0] SAT_MIN   = P_W'(-128);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   // Product kept at full width so the rounding add and shift see every bit.
   function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc,
                                          input logic [MUL_W-1:0] scale,
                                          input logic [4:0]       shift,
                                          input logic             relu);
      logic signed [P_W-1:0] p;
      logic signed [P_W-1:0] r;
      logic [7:0]            q;
      p = $signed({{(P_W-ACC_W){acc[ACC_W-1]}}, acc}) *
          $signed({{(P_W-MUL_W){1'b0}}, scale});
      if (shift == 5'd0) begin
         r = p;
      end else begin
         r = (p + $signed(ROUND_ONE << (shift - 5'd1))) >>> shift;
      end
      if (relu && r[P_W-1]) begin
         r = '0;
      end else begin
         r = r;
      end
      if (r > SAT_MAX) begin
         q = 8'h7F;
      end else if (r < SAT_MIN) begin
         q = 8'h80;
      end else begin
         q = r[7:0];
      end
      return q;
   endfunction

   state_t                 state_q, state_d;
   logic [GRP_W-1:0]       grp_q, grp_d;
   logic [ACC_W*LANES-1:0] data_q, data_d;
   logic [MUL_W-1:0]       scale_q, scale_d;
   logic [4:0]             shift_q, shift_d;
   logic                   relu_q, relu_d;
   logic [8*LANES-1:0]     work_q, work_d;
   logic [8*LANES-1:0]     ofmap_q, ofmap_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;

   // Next-state, operand latch and per-group requantization.
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      data_d  = data_q;
      scale_d = scale_q;
      shift_d = shift_q;
      relu_d  = relu_q;
      work_d  = work_q;
      ofmap_d = ofmap_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               data_d  = data_i;
               scale_d = scale_i;
               shift_d = shift_i;
               relu_d  = relu_en;
               grp_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_RUN: begin
            for (int l = 0; l < LANES_PER_CYC; l++) begin
               work_d[8*(int'(grp_q)*LANES_PER_CYC + l) +: 8] =
                  requant(data_q[ACC_W*(int'(grp_q)*LANES_PER_CYC + l) +: ACC_W],
                          scale_q, shift_q, relu_q);
            end
            if (grp_q == LAST_GRP) begin
               ofmap_d = work_d;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               grp_d   = '0;
               state_d = S_IDLE;
            end else begin
               grp_d   = grp_q + GRP_W'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            grp_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grp_q   <= '0;
         data_q  <= '0;
         scale_q <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         work_q  <= '0;
         ofmap_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         data_q  <= data_d;
         scale_q <= scale_d;
         shift_q <= shift_d;
         relu_q  <= relu_d;
         work_q  <= work_d;
         ofmap_q <= ofmap_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o           = busy_q;
   assign ofmap_rescaled   = ofmap_q;
   assign valid_o_rescaled = valid_q;

endmodule

// File: tb/tb_conv_rescale.sv
// Scoreboard bench for conv_rescale: directed vectors push expected outputs,
// a monitor pops and compares on every valid pulse and checks output hold.
module tb_conv_rescale;

   localparam int LANES = 40;
   localparam int ACC_W = 24;
   localparam int MUL_W = 16;
   localparam int LPC   = 8;
   localparam int G     = LANES / LPC;
   localparam int OW    = 8 * LANES;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   valid_i = 1'b0;
   logic [ACC_W*LANES-1:0] data_i = '0;
   logic [MUL_W-1:0]       scale_i = '0;
   logic [4:0]             shift_i = '0;
   logic                   relu_en = 1'b0;
   logic                   busy_o;
   logic [OW-1:0]          ofmap_rescaled;
   logic                   valid_o_rescaled;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [OW-1:0]          sb_q[$];
   int                     cyc_q[$];
   logic [OW-1:0]          last_ofmap = '0;
   logic [ACC_W*LANES-1:0] vec;
   logic [OW-1:0]          expv;

   conv_rescale #(.LANES(LANES), .ACC_W(ACC_W), .MUL_W(MUL_W), .LANES_PER_CYC(LPC)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
      .scale_i(scale_i), .shift_i(shift_i), .relu_en(relu_en), .busy_o(busy_o),
      .ofmap_rescaled(ofmap_rescaled), .valid_o_rescaled(valid_o_rescaled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: samples just after each rising edge.
   always begin
      logic [OW-1:0] e;
      int            ec;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         last_ofmap = '0;
      end else if (valid_o_rescaled === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", OW'(1), OW'(0));
         end else begin
            e  = sb_q.pop_front();
            ec = cyc_q.pop_front();
            chk("ofmap", ofmap_rescaled, e);
            chk("latency_cycle", OW'(cyc), OW'(ec));
            last_ofmap = e;
         end
      end else begin
         chk("ofmap_hold", ofmap_rescaled, last_ofmap);
      end
   end

   task automatic clr();
      vec  = '0;
      expv = '0;
   endtask

   task automatic set_lane(input int i, input int acc, input int e);
      vec[ACC_W*i +: ACC_W] = ACC_W'(acc);
      expv[8*i +: 8]        = 8'(e);
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic send(input logic [MUL_W-1:0] sc, input logic [4:0] sh, input logic rl,
                       input bit accept);
      data_i  = vec;
      scale_i = sc;
      shift_i = sh;
      relu_en = rl;
      valid_i = 1'b1;
      if (accept) begin
         sb_q.push_back(expv);
         cyc_q.push_back(cyc + 1 + G);
      end
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         chk("timeout", OW'(sb_q.size()), OW'(0));
         sb_q.delete();
         cyc_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      clr();
      repeat (2) @(negedge clk);
      chk("reset_busy", OW'(busy_o), OW'(0));
      chk("reset_valid", OW'(valid_o_rescaled), OW'(0));
      chk("reset_ofmap", ofmap_rescaled, OW'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Passthrough and saturation
      clr();
      set_lane(0, 100, 8'h64); set_lane(1, 200, 8'h7F);
      set_lane(2, -300, 8'h80); set_lane(39, -1, 8'hFF);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      chk("busy_after_accept", OW'(busy_o), OW'(1));
      wait_done();

      // Rounding half toward +inf
      clr();
      set_lane(0, 3, 2); set_lane(1, -3, -1); set_lane(2, 1, 1); set_lane(3, -1, 0);
      send(16'd1, 5'd1, 1'b0, 1'b1);
      wait_done();
      clr();
      set_lane(0, 5, 4); set_lane(20, -5, -4);
      send(16'd3, 5'd2, 1'b0, 1'b1);
      wait_done();
      clr();
      set_lane(8, 1000, 73); set_lane(15, -1000, -73);
      set_lane(16, 8388607, 127); set_lane(31, -8388608, -128);
      send(16'd300, 5'd12, 1'b0, 1'b0);
      sb_q.push_back(expv);
      cyc_q.push_back(cyc + G);
      wait_done();
      clr();
      set_lane(0, 8388607, 127); set_lane(1, -8388608, -128);
      send(16'hFFFF, 5'd31, 1'b0, 1'b1);
      wait_done();

      // ReLU
      clr();
      set_lane(0, -5, 0); set_lane(1, 0, 0); set_lane(2, 130, 127); set_lane(33, -300, 0);
      send(16'd1, 5'd0, 1'b1, 1'b1);
      wait_done();

      // Busy drop, then acceptance in the valid cycle
      clr();
      set_lane(0, 10, 10); set_lane(17, -50, -50);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      clr();
      set_lane(0, 99, 99); set_lane(17, 77, 77);
      send(16'd2, 5'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("valid_at_c_present", OW'(valid_o_rescaled), OW'(1));
      clr();
      set_lane(0, -7, -7); set_lane(39, 55, 55);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      wait_done();

      // Lane ordering across every group boundary
      clr();
      for (int i = 0; i < LANES; i++) set_lane(i, i - 20, i - 20);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      wait_done();

      // Mid-run reset aborts the vector
      clr();
      for (int i = 0; i < LANES; i++) set_lane(i, 90, 90);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      cyc_q.delete();
      chk("midrst_busy", OW'(busy_o), OW'(0));
      chk("midrst_valid", OW'(valid_o_rescaled), OW'(0));
      chk("midrst_ofmap", ofmap_rescaled, OW'(0));
      repeat (8) @(negedge clk);
      clr();
      for (int i = 0; i < LANES; i++) set_lane(i, 20 - i, 20 - i);
      send(16'd1, 5'd0, 1'b0, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_rescale.md
# conv_rescale

Requantizes one vector of signed conv-layer accumulator outputs into packed signed 8-bit values, asserting a one-cycle valid pulse when the whole vector is ready. It sits between a conv engine's accumulator output and every consumer of the `*_rescaled` buses, including the result-inspection test logic. It produces the `conv*_ofmap_rescaled` / `conv*_valid_o_rescaled` pair. Lanes are processed `LANES_PER_CYC` at a time to bound multiplier count.

## Interface
- `LANES`, 40, number of lanes per vector (40 for conv1, 36 for conv3).
- `ACC_W`, 24, signed accumulator width per lane.
- `MUL_W`, 16, unsigned scale multiplier width.
- `LANES_PER_CYC`, 8, lanes requantized per cycle.
  - `LANES` must be a multiple of this value.
  - G = `LANES`/`LANES_PER_CYC`.

- `clk`, in, 1, sole clock, rising edge.
- `rst_n`, in, 1, reset.
  - One clock; reset is synchronous and active-low.
- `valid_i`, in, 1, `data_i` and the scale controls are valid this cycle.
- `data_i`, in, `ACC_W*LANES`, lane i at `[ACC_W*i +: ACC_W]`, two's complement.
- `scale_i`, in, `MUL_W`, unsigned multiplier.
- `shift_i`, in, 5, right-shift amount, 0–31.
- `relu_en`, in, 1, clamp negatives to 0.
- `busy_o`, out, 1, vector in flight; `valid_i` is ignored while this is high.
- `ofmap_rescaled`, out, `8*LANES`, lane i at `[8*i +: 8]`, signed int8.
- `valid_o_rescaled`, out, 1, one-cycle pulse: `ofmap_rescaled` has just been updated.

## Operation
- **States:** IDLE and RUN. The group counter `grp` runs 0..G-1.
- **IDLE:**
  - `valid_i`=1 latches `data_i`, `scale_i`, `shift_i` and `relu_en` into internal registers.
  - Sets `grp`=0, `busy_o`=1 and moves to RUN.
- **RUN:** each cycle processes lanes `grp*LANES_PER_CYC` .. `+LANES_PER_CYC-1`, using only the latched copies.
  - p = signed(acc) × unsigned(scale), computed at full width `ACC_W+MUL_W+1`. No truncation before the shift.
  - If shift>0: r = (p + (1<<(shift-1))) >>> shift, an arithmetic shift that rounds half toward +inf.
  - If shift=0: r = p.
  - If `relu_en` and r<0: r = 0.
  - Saturate to [-128, 127] and write into the internal work buffer.
- **Last group** (`grp`=G-1):
  - Write the work buffer, including the final group, to `ofmap_rescaled` in one step.
  - Pulse `valid_o_rescaled`, clear `busy_o` and return to IDLE.
- **Output hold:** `ofmap_rescaled` changes only on completion and holds its value until the next completion. Consumers never see a partially updated vector.
- **`valid_i` handling:**
  - `valid_i` while `busy_o`=1 is dropped silently: no queueing, and latched operands are unaffected.
  - `valid_i` in the cycle `valid_o_rescaled` is high is accepted, because `busy_o` is already 0.

## Timing
- **Reset** (rst_n=0 at an edge):
  - `busy_o`=0, `valid_o_rescaled`=0, `ofmap_rescaled`=0.
  - State IDLE, `grp`=0, work buffer=0.
- **Reset mid-RUN:** aborts the vector. No valid pulse is produced, and the output clears to 0.
- **Latency and throughput:**
  - `valid_i` accepted at edge k.
  - Groups 0..G-1 are computed on edges k+1..k+G.
  - `ofmap_rescaled` is updated, and `valid_o_rescaled`=1 and `busy_o`=0, during the cycle after edge k+G.
  - Latency is G cycles. Throughput is one vector per G+1 cycles.
- **`busy_o`:** registered; high during the cycles after edges k..k+G-1.
- **`valid_o_rescaled`:** exactly one cycle wide per accepted vector, never asserted otherwise.
- **Critical path:** one `ACC_W`×`MUL_W` multiply plus add, shift and saturate per lane. No pipelining inside a group.

## Test plan
- **Passthrough and saturation** (`LANES`=40, `LANES_PER_CYC`=8, scale=1, shift=0, relu=0):
  - Stimulus: lane0=100, lane1=200, lane2=-300, lane39=-1.
  - Required: bytes 0x64, 0x7F, 0x80, 0xFF.
  - `valid_o_rescaled` is high exactly 5 cycles after acceptance, for 1 cycle.
- **Rounding** (scale=1, shift=1):
  - Stimulus: lanes 3, -3, 1, -1.
  - Required: 2, -1, 1, 0.
  - Also scale=3, shift=2, lane=5: required 4, since (15+2)>>2.
- **ReLU** (relu=1):
  - Stimulus: lanes -5, 0, 130.
  - Required: 0, 0, 127.
  - Negative saturation never appears.
- **Busy drop:**
  - Stimulus: vector A accepted; vector B pulsed on `valid_i` 2 cycles later.
  - Required: only A's result appears, with a single valid pulse.
  - Vector C presented in the cycle `valid_o_rescaled`=1 is accepted, and its result arrives 5 cycles later.
- **Lane ordering:**
  - Stimulus: lane i = i-20, scale=1, shift=0.
  - Required: output byte i = i-20 for all 40 lanes, confirming every group boundary.
- **Mid-run reset:**
  - Stimulus: rst_n=0 for one cycle 2 cycles after acceptance.
  - Required: outputs are 0, no valid pulse, `busy_o`=0.
  - A next vector completes normally.
